// File: rtl/lca_obi_demux.sv
// OBI data-port demultiplexer: routes core requests to NT address-mapped targets,
// keeps responses in order with a small target-id FIFO, and answers unmapped accesses itself.
module lca_obi_demux #(
  parameter int unsigned NT      = 4,
  parameter int unsigned MAX_OUT = 2,
  parameter logic [NT-1:0][31:0] TGT_BASE = {32'h3000_0000, 32'h2000_0000,
                                             32'h1010_0000, 32'h1000_0000},
  parameter logic [NT-1:0][31:0] TGT_MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                             32'hFFF0_0000, 32'hFFF0_0000}
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 h_req_i,
  output logic                 h_gnt_o,
  input  logic [31:0]          h_addr_i,
  input  logic                 h_we_i,
  input  logic [3:0]           h_be_i,
  input  logic [31:0]          h_wdata_i,
  output logic                 h_rvalid_o,
  output logic [31:0]          h_rdata_o,
  output logic                 h_err_o,
  output logic [NT-1:0]        t_req_o,
  input  logic [NT-1:0]        t_gnt_i,
  output logic [31:0]          t_addr_o,
  output logic                 t_we_o,
  output logic [3:0]           t_be_o,
  output logic [31:0]          t_wdata_o,
  input  logic [NT-1:0]        t_rvalid_i,
  input  logic [NT-1:0][31:0]  t_rdata_i,
  output logic                 proto_err_o
);

  localparam int unsigned SW = $clog2(NT + 1);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [SW-1:0] ERR_SEL = SW'(NT);

  logic [MAX_OUT-1:0][SW-1:0] fifo_q, fifo_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [SW-1:0]              last_tgt_q, last_tgt_d;
  logic                       err_pend_q, err_pend_d;
  logic                       proto_err_q, proto_err_d;

  logic [SW-1:0] sel, head;
  logic          stall, tgt_gnt, push, pop, head_rvalid, stray;
  logic [31:0]   head_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Descending scan so the lowest matching target wins.
  always_comb begin
    sel = ERR_SEL;
    for (int i = int'(NT) - 1; i >= 0; i--) begin
      if ((h_addr_i & TGT_MASK[i]) == TGT_BASE[i]) sel = SW'(i);
    end
  end

  // Only the most recent target may be pipelined, so responses can never reorder.
  assign stall = (count_q == CW'(MAX_OUT)) | ((count_q != '0) & (sel != last_tgt_q));
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    t_req_o     = '0;
    tgt_gnt     = 1'b0;
    head_rvalid = 1'b0;
    head_rdata  = '0;
    stray       = 1'b0;
    for (int i = 0; i < int'(NT); i++) begin
      if (sel == SW'(i)) begin
        t_req_o[i] = h_req_i & ~stall;
        tgt_gnt    = t_gnt_i[i];
      end
      if (head == SW'(i)) begin
        head_rvalid = t_rvalid_i[i];
        head_rdata  = t_rdata_i[i];
      end
      if (t_rvalid_i[i] & ((count_q == '0) | (head != SW'(i)))) stray = 1'b1;
    end
  end

  assign h_gnt_o    = h_req_i & ~stall & ((sel == ERR_SEL) | tgt_gnt);
  assign h_rvalid_o = (count_q != '0) & ((head == ERR_SEL) ? err_pend_q : head_rvalid);
  assign h_rdata_o  = (h_rvalid_o & (head != ERR_SEL)) ? head_rdata : 32'h0;
  assign h_err_o    = h_rvalid_o & (head == ERR_SEL);
  assign t_addr_o   = h_addr_i;
  assign t_we_o     = h_we_i;
  assign t_be_o     = h_be_i;
  assign t_wdata_o  = h_wdata_i;
  assign proto_err_o = proto_err_q;

  assign push = h_gnt_o;
  assign pop  = h_rvalid_o;

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_tgt_d  = last_tgt_q;
    err_pend_d  = err_pend_q;
    proto_err_d = proto_err_q | stray;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      last_tgt_d       = sel;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new unmapped accept re-arms the internal responder even while the previous one pops.
    if (push & (sel == ERR_SEL))      err_pend_d = 1'b1;
    else if (pop & (head == ERR_SEL)) err_pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_tgt_q  <= '0;
      err_pend_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_tgt_q  <= last_tgt_d;
      err_pend_q  <= err_pend_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_lca_obi_demux.sv
// Directed bench for lca_obi_demux: inputs change 1ns after a rising edge,
// outputs are checked 3ns after the edge, well clear of the next one.
module tb_lca_obi_demux;
  localparam logic [31:0] A_T0 = 32'h1000_0000;
  localparam logic [31:0] A_T1 = 32'h1010_0000;
  localparam logic [31:0] A_T2 = 32'h2000_0000;
  localparam logic [31:0] A_UM = 32'h0F00_0000;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             h_req_i, h_gnt_o, h_we_i, h_rvalid_o, h_err_o, t_we_o, proto_err_o;
  logic [31:0]      h_addr_i, h_wdata_i, h_rdata_o, t_addr_o, t_wdata_o;
  logic [3:0]       h_be_i, t_be_o, t_req_o, t_gnt_i, t_rvalid_i;
  logic [3:0][31:0] t_rdata_i;

  int checks = 0;
  int failures = 0;

  lca_obi_demux #(.NT(4), .MAX_OUT(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .h_req_i(h_req_i), .h_gnt_o(h_gnt_o), .h_addr_i(h_addr_i), .h_we_i(h_we_i),
    .h_be_i(h_be_i), .h_wdata_i(h_wdata_i), .h_rvalid_o(h_rvalid_o),
    .h_rdata_o(h_rdata_o), .h_err_o(h_err_o),
    .t_req_o(t_req_o), .t_gnt_i(t_gnt_i), .t_addr_o(t_addr_o), .t_we_o(t_we_o),
    .t_be_o(t_be_o), .t_wdata_o(t_wdata_o), .t_rvalid_i(t_rvalid_i),
    .t_rdata_i(t_rdata_i), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    h_req_i = 0; h_addr_i = 0; h_we_i = 0; h_be_i = 0; h_wdata_i = 0;
    t_gnt_i = 0; t_rvalid_i = 0; t_rdata_i = '0;
  endtask

  task automatic host_req(input logic [31:0] addr, input logic we, input logic [3:0] gnt);
    h_req_i = 1; h_addr_i = addr; h_we_i = we; h_be_i = 4'hF; t_gnt_i = gnt;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle_inputs();
    #12;
    checks++; if (h_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_gnt: got %0b want 0", h_gnt_o); end
    checks++; if (h_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %0b want 0", h_rvalid_o); end
    checks++; if (t_req_o !== 4'b0) begin failures++; $display("FAIL reset_treq: got %b want 0000", t_req_o); end
    checks++; if (proto_err_o !== 1'b0) begin failures++; $display("FAIL reset_proto: got %0b want 0", proto_err_o); end
    checks++; if (dut.count_q !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_single_read();
    step(); host_req(A_T1 + 32'h10, 1'b0, 4'b0010); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL single_gnt: got %0b want 1", h_gnt_o); end
    checks++; if (t_req_o !== 4'b0010) begin failures++; $display("FAIL single_treq: got %b want 0010", t_req_o); end
    checks++; if (t_addr_o !== 32'h1010_0010) begin failures++; $display("FAIL single_addr: got %h want 10100010", t_addr_o); end
    step(); idle_inputs(); t_rvalid_i = 4'b0010; t_rdata_i[1] = 32'hDEAD_BEEF; #2;
    checks++; if (h_rvalid_o !== 1'b1) begin failures++; $display("FAIL single_rvalid: got %0b want 1", h_rvalid_o); end
    checks++; if (h_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata: got %h want deadbeef", h_rdata_o); end
    checks++; if (h_err_o !== 1'b0) begin failures++; $display("FAIL single_err: got %0b want 0", h_err_o); end
    step(); idle_inputs(); #2;
    checks++; if (dut.count_q !== 2'd0) begin failures++; $display("FAIL single_count: got %0d want 0", dut.count_q); end
    checks++; if (h_rvalid_o !== 1'b0) begin failures++; $display("FAIL single_rvalid_off: got %0b want 0", h_rvalid_o); end
  endtask

  task automatic test_back_to_back();
    step(); host_req(A_T0, 1'b0, 4'b0001); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL b2b_gnt0: got %0b want 1", h_gnt_o); end
    step(); host_req(A_T0 + 4, 1'b0, 4'b0001); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL b2b_gnt1: got %0b want 1", h_gnt_o); end
    step(); host_req(A_T0 + 8, 1'b0, 4'b0001); t_rvalid_i = 4'b0001; t_rdata_i[0] = 32'h1111_0000; #2;
    checks++; if (h_gnt_o !== 1'b0) begin failures++; $display("FAIL b2b_full_stall: got %0b want 0", h_gnt_o); end
    checks++; if (t_req_o !== 4'b0000) begin failures++; $display("FAIL b2b_full_treq: got %b want 0000", t_req_o); end
    checks++; if (h_rvalid_o !== 1'b1 || h_rdata_o !== 32'h1111_0000) begin failures++; $display("FAIL b2b_rsp0: got v=%0b d=%h want v=1 d=11110000", h_rvalid_o, h_rdata_o); end
    step(); t_rdata_i[0] = 32'h2222_0000; #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL b2b_gnt2: got %0b want 1", h_gnt_o); end
    checks++; if (h_rvalid_o !== 1'b1 || h_rdata_o !== 32'h2222_0000) begin failures++; $display("FAIL b2b_rsp1: got v=%0b d=%h want v=1 d=22220000", h_rvalid_o, h_rdata_o); end
    step(); idle_inputs(); #2;
    checks++; if (h_rvalid_o !== 1'b0) begin failures++; $display("FAIL b2b_gap: got %0b want 0", h_rvalid_o); end
    step(); t_rvalid_i = 4'b0001; t_rdata_i[0] = 32'h3333_0000; #2;
    checks++; if (h_rvalid_o !== 1'b1 || h_rdata_o !== 32'h3333_0000) begin failures++; $display("FAIL b2b_rsp2: got v=%0b d=%h want v=1 d=33330000", h_rvalid_o, h_rdata_o); end
    step(); idle_inputs(); #2;
    checks++; if (dut.count_q !== 2'd0) begin failures++; $display("FAIL b2b_count: got %0d want 0", dut.count_q); end
  endtask

  task automatic test_cross_target();
    step(); host_req(A_T0, 1'b0, 4'b0001); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL cross_gnt0: got %0b want 1", h_gnt_o); end
    step(); host_req(A_T2 + 32'h10, 1'b0, 4'b0100); #2;
    checks++; if (h_gnt_o !== 1'b0 || t_req_o !== 4'b0000) begin failures++; $display("FAIL cross_stall1: got g=%0b r=%b want g=0 r=0000", h_gnt_o, t_req_o); end
    step(); t_rvalid_i = 4'b0001; t_rdata_i[0] = 32'hA5A5_A5A5; #2;
    checks++; if (h_gnt_o !== 1'b0 || t_req_o !== 4'b0000) begin failures++; $display("FAIL cross_stall2: got g=%0b r=%b want g=0 r=0000", h_gnt_o, t_req_o); end
    checks++; if (h_rvalid_o !== 1'b1 || h_rdata_o !== 32'hA5A5_A5A5) begin failures++; $display("FAIL cross_rsp0: got v=%0b d=%h want v=1 d=a5a5a5a5", h_rvalid_o, h_rdata_o); end
    step(); t_rvalid_i = 4'b0000; #2;
    checks++; if (h_gnt_o !== 1'b1 || t_req_o !== 4'b0100) begin failures++; $display("FAIL cross_gnt2: got g=%0b r=%b want g=1 r=0100", h_gnt_o, t_req_o); end
    step(); idle_inputs(); t_rvalid_i = 4'b0100; t_rdata_i[2] = 32'h5A5A_0002; #2;
    checks++; if (h_rvalid_o !== 1'b1 || h_rdata_o !== 32'h5A5A_0002) begin failures++; $display("FAIL cross_rsp2: got v=%0b d=%h want v=1 d=5a5a0002", h_rvalid_o, h_rdata_o); end
    step(); idle_inputs();
  endtask

  task automatic test_unmapped();
    step(); host_req(A_UM, 1'b1, 4'b1111); h_wdata_i = 32'h1234_5678; #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL um_gnt: got %0b want 1", h_gnt_o); end
    checks++; if (t_req_o !== 4'b0000) begin failures++; $display("FAIL um_treq: got %b want 0000", t_req_o); end
    checks++; if (t_we_o !== 1'b1 || t_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL um_bcast: got we=%0b d=%h want we=1 d=12345678", t_we_o, t_wdata_o); end
    step(); idle_inputs(); t_rdata_i = {4{32'hFFFF_FFFF}}; #2;
    checks++; if (h_rvalid_o !== 1'b1 || h_err_o !== 1'b1) begin failures++; $display("FAIL um_rsp: got v=%0b e=%0b want v=1 e=1", h_rvalid_o, h_err_o); end
    checks++; if (h_rdata_o !== 32'h0) begin failures++; $display("FAIL um_rdata: got %h want 0", h_rdata_o); end
    step(); idle_inputs(); #2;
    checks++; if (h_rvalid_o !== 1'b0 || dut.count_q !== 2'd0) begin failures++; $display("FAIL um_done: got v=%0b c=%0d want v=0 c=0", h_rvalid_o, dut.count_q); end
  endtask

  task automatic test_unmapped_pipelined();
    step(); host_req(A_UM, 1'b0, 4'b0000); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL ump_gnt0: got %0b want 1", h_gnt_o); end
    step(); host_req(A_UM + 4, 1'b0, 4'b0000); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL ump_gnt1: got %0b want 1", h_gnt_o); end
    checks++; if (h_rvalid_o !== 1'b1 || h_err_o !== 1'b1) begin failures++; $display("FAIL ump_rsp0: got v=%0b e=%0b want v=1 e=1", h_rvalid_o, h_err_o); end
    step(); idle_inputs(); #2;
    checks++; if (h_rvalid_o !== 1'b1 || h_err_o !== 1'b1) begin failures++; $display("FAIL ump_rsp1: got v=%0b e=%0b want v=1 e=1", h_rvalid_o, h_err_o); end
    step(); #2;
    checks++; if (h_rvalid_o !== 1'b0 || dut.count_q !== 2'd0) begin failures++; $display("FAIL ump_done: got v=%0b c=%0d want v=0 c=0", h_rvalid_o, dut.count_q); end
  endtask

  task automatic test_proto_err();
    step(); idle_inputs(); t_rvalid_i = 4'b1000; t_rdata_i[3] = 32'h0000_0BAD; #2;
    checks++; if (h_rvalid_o !== 1'b0) begin failures++; $display("FAIL proto_fwd: got %0b want 0", h_rvalid_o); end
    step(); t_rvalid_i = 4'b0000; #2;
    checks++; if (proto_err_o !== 1'b1) begin failures++; $display("FAIL proto_set: got %0b want 1", proto_err_o); end
    step(); step(); #2;
    checks++; if (proto_err_o !== 1'b1) begin failures++; $display("FAIL proto_sticky: got %0b want 1", proto_err_o); end
    rst_ni = 0; #1;
    checks++; if (proto_err_o !== 1'b0) begin failures++; $display("FAIL proto_clear: got %0b want 0", proto_err_o); end
    @(negedge clk_i); rst_ni = 1;
  endtask

  task automatic test_reset_mid();
    step(); host_req(A_T0, 1'b0, 4'b0001);
    step(); host_req(A_T0 + 4, 1'b0, 4'b0001);
    step(); idle_inputs(); t_rvalid_i = 4'b0001; t_rdata_i[0] = 32'hCAFE_0001; #2;
    checks++; if (dut.count_q !== 2'd2 || h_rvalid_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got c=%0d v=%0b want c=2 v=1", dut.count_q, h_rvalid_o); end
    rst_ni = 0; #1;
    checks++; if (h_rvalid_o !== 1'b0 || dut.count_q !== 2'd0) begin failures++; $display("FAIL rstmid_flush: got v=%0b c=%0d want v=0 c=0", h_rvalid_o, dut.count_q); end
    @(negedge clk_i); idle_inputs(); rst_ni = 1;
    step(); host_req(A_T1, 1'b0, 4'b0010); #2;
    checks++; if (h_gnt_o !== 1'b1) begin failures++; $display("FAIL rstmid_gnt: got %0b want 1", h_gnt_o); end
    step(); idle_inputs(); t_rvalid_i = 4'b0010; t_rdata_i[1] = 32'h0BEE_F00D; #2;
    checks++; if (h_rvalid_o !== 1'b1 || h_rdata_o !== 32'h0BEE_F00D) begin failures++; $display("FAIL rstmid_rsp: got v=%0b d=%h want v=1 d=0beef00d", h_rvalid_o, h_rdata_o); end
    checks++; if (proto_err_o !== 1'b0) begin failures++; $display("FAIL rstmid_noproto: got %0b want 0", proto_err_o); end
    step(); idle_inputs(); t_rvalid_i = 4'b0001;
    step(); t_rvalid_i = 4'b0000; #2;
    checks++; if (proto_err_o !== 1'b1) begin failures++; $display("FAIL rstmid_late: got %0b want 1", proto_err_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_cross_target();
    test_unmapped();
    test_unmapped_pipelined();
    test_proto_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
